router_fsm_ctrl: RTL

Control FSM for the 1x3 router input path. It decodes each packet's 2-bit destination from the header byte and checks that the destination FIFO is free. It then sequences the byte register through header, payload, parity and parity-check phases. It also stalls on FIFO full, resumes after full, and aborts on a per-destination soft reset.

---
 rtl/router_fsm_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/router_fsm_ctrl.sv
// Control FSM for the 1x3 router input path. It decodes the header destination,
// sequences the byte register through the packet phases, and handles FIFO-full stalls and soft resets.
module router_fsm_ctrl #(
  parameter int NUM_DEST = 3,
  parameter int ADDR_W   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                packet_valid,
  input  logic [ADDR_W-1:0]   datain,
  input  logic                fifo_full,
  input  logic [NUM_DEST-1:0] fifo_empty,
  input  logic [NUM_DEST-1:0] soft_reset,
  input  logic                parity_done,
  input  logic                low_packet_valid,
  output logic [ADDR_W-1:0]   dest_addr,
  output logic                detect_add,
  output logic                lfd_state,
  output logic                ld_state,
  output logic                laf_state,
  output logic                full_state,
  output logic                rst_int_reg,
  output logic                write_enb_reg,
  output logic                busy,
  output logic [7:0]          state_dbg
);

  localparam logic [7:0] DECODE          = 8'b0000_0001;
  localparam logic [7:0] LOAD_FIRST_DATA = 8'b0000_0010;
  localparam logic [7:0] LOAD_DATA       = 8'b0000_0100;
  localparam logic [7:0] LOAD_PARITY     = 8'b0000_1000;
  localparam logic [7:0] CHECK_PARITY    = 8'b0001_0000;
  localparam logic [7:0] FIFO_FULL       = 8'b0010_0000;
  localparam logic [7:0] LOAD_AFTER_FULL = 8'b0100_0000;
  localparam logic [7:0] WAIT_TILL_EMPTY = 8'b1000_0000;

  logic [7:0]        state, state_next;
  logic [ADDR_W-1:0] dest_next;
  logic              hdr_addr_ok;
  logic              hdr_empty;
  logic              dest_empty;
  logic              dest_soft;

  // Per-destination lookups by loop so an out-of-range address (3) simply matches nothing.
  always_comb begin
    hdr_addr_ok = 1'b0;
    hdr_empty   = 1'b0;
    dest_empty  = 1'b0;
    dest_soft   = 1'b0;
    for (int i = 0; i < NUM_DEST; i++) begin
      if (datain == ADDR_W'(i)) begin
        hdr_addr_ok = 1'b1;
        hdr_empty   = fifo_empty[i];
      end
      if (dest_addr == ADDR_W'(i)) begin
        dest_empty = fifo_empty[i];
        dest_soft  = soft_reset[i];
      end
    end
  end

  always_comb begin
    state_next = state;
    dest_next  = dest_addr;
    if (state != DECODE && dest_soft) begin
      state_next = DECODE;
    end else begin
      case (state)
        DECODE: begin
          if (packet_valid && hdr_addr_ok) begin
            dest_next  = datain;
            state_next = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        WAIT_TILL_EMPTY: begin
          if (dest_empty) state_next = LOAD_FIRST_DATA;
        end
        LOAD_FIRST_DATA: state_next = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)         state_next = FIFO_FULL;
          else if (!packet_valid) state_next = LOAD_PARITY;
        end
        LOAD_PARITY:  state_next = CHECK_PARITY;
        CHECK_PARITY: state_next = fifo_full ? FIFO_FULL : DECODE;
        FIFO_FULL: begin
          if (!fifo_full) state_next = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)           state_next = DECODE;
          else if (low_packet_valid) state_next = LOAD_PARITY;
          else                       state_next = LOAD_DATA;
        end
        // Any corrupted one-hot pattern falls back to a clean DECODE.
        default: state_next = DECODE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= DECODE;
      dest_addr <= '0;
    end else begin
      state     <= state_next;
      dest_addr <= dest_next;
    end
  end

  // Handshake: the source keeps its byte on the bus while busy=1; a byte is taken
  // on a rising edge only when busy=0 (DECODE for headers, LOAD_DATA for payload).
  assign detect_add    = (state == DECODE);
  assign lfd_state     = (state == LOAD_FIRST_DATA);
  assign ld_state      = (state == LOAD_DATA);
  assign laf_state     = (state == LOAD_AFTER_FULL);
  assign full_state    = (state == FIFO_FULL);
  assign rst_int_reg   = (state == CHECK_PARITY);
  assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                         (state == LOAD_AFTER_FULL);
  assign busy          = !((state == DECODE) || (state == LOAD_DATA));
  assign state_dbg     = state;

endmodule
